// File: rtl/pe_array_fused_acc.sv
// pe_array_fused_acc
//   Bit-fusion dot-product array. N_PE PEs each multiply N_DOT pairs of 2-bit
//   slices. Each PE result is sign-configured and shifted according to the
//   latched precision, then all PEs are summed. The sum is accumulated over a
//   programmable number of beats on top of a bias, with ready/valid flow
//   control on both the input and the output side.
//
// Ports
//   CLK, RST         clock, synchronous active-low reset
//   i_Start          launch a run; latches i_Precision, i_AccLen, i_Bias
//   i_Precision      {act[3:2], wgt[1:0]} codes: 00=2b 01=4b 10=8b 11=2b
//   i_AccLen         beats per run (0 runs one beat)
//   i_Bias           signed initial accumulator value
//   i_Valid/o_Ready  operand beat handshake
//   i_Act/i_Weight   PE i lane j slice at [2*(i*N_DOT+j) +: 2]
//   i_Flush          abort run, drop in-flight data
//   o_Valid/i_Ready  result handshake
//   o_Psum           signed accumulated result
//   o_Ovf            sticky signed overflow for the current run
//   o_Busy           FSM not idle
//
// state | meaning
// IDLE  | waiting for i_Start
// ACCUM | accepting operand beats until the programmed count is reached
// DRAIN | last beat accepted, waiting for the pipeline to empty
// OUT   | result presented, waiting for i_Ready

module pe_array_fused_acc #(
    parameter int N_PE      = 16,
    parameter int N_DOT     = 4,
    parameter int BITS_PSUM = 32,
    parameter int LEN_W     = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    i_Start,
    input  logic [3:0]              i_Precision,
    input  logic [LEN_W-1:0]        i_AccLen,
    input  logic [BITS_PSUM-1:0]    i_Bias,
    input  logic                    i_Valid,
    output logic                    o_Ready,
    input  logic [2*N_DOT*N_PE-1:0] i_Act,
    input  logic [2*N_DOT*N_PE-1:0] i_Weight,
    input  logic                    i_Flush,
    output logic                    o_Valid,
    input  logic                    i_Ready,
    output logic [BITS_PSUM-1:0]    o_Psum,
    output logic                    o_Ovf,
    output logic                    o_Busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

    state_t                    state_q, state_d;
    logic [1:0]                pa_q, pw_q;
    logic [LEN_W-1:0]          len_q, cnt_q;
    logic                      op_vld_q, mrg_vld_q;
    logic [2*N_DOT*N_PE-1:0]   act_q, wgt_q;
    logic [BITS_PSUM-1:0]      mrg_q, merge_d;
    logic [BITS_PSUM-1:0]      acc_q, sum_d;
    logic                      ovf_q, add_ovf;
    logic                      accept, last_beat, start_ok;

    // One PE: the highest slice position in a fused operand is the sign slice.
    function automatic logic [BITS_PSUM-1:0] pe_term(
        input logic [2*N_DOT-1:0] a,
        input logic [2*N_DOT-1:0] w,
        input int                 i,
        input logic [1:0]         pa,
        input logic [1:0]         pw
    );
        int               wi, ai, dot;
        logic             sa, sw;
        logic signed [2:0] av, wv;
        wi  = i & ((1 << pw) - 1);
        ai  = (i >> pw) & ((1 << pa) - 1);
        sa  = (ai == ((1 << pa) - 1));
        sw  = (wi == ((1 << pw) - 1));
        dot = 0;
        for (int j = 0; j < N_DOT; j++) begin
            av  = {sa & a[2*j+1], a[2*j +: 2]};
            wv  = {sw & w[2*j+1], w[2*j +: 2]};
            dot = dot + int'(av) * int'(wv);
        end
        return BITS_PSUM'(dot) << (2 * (ai + wi));
    endfunction

    always_comb begin
        merge_d = '0;
        for (int i = 0; i < N_PE; i++) begin
            merge_d = merge_d + pe_term(act_q[2*N_DOT*i +: 2*N_DOT],
                                        wgt_q[2*N_DOT*i +: 2*N_DOT], i, pa_q, pw_q);
        end
    end

    assign sum_d   = acc_q + mrg_q;
    assign add_ovf = (acc_q[BITS_PSUM-1] == mrg_q[BITS_PSUM-1]) &&
                     (sum_d[BITS_PSUM-1] != acc_q[BITS_PSUM-1]);

    assign o_Ready   = (state_q == ACCUM);
    assign o_Valid   = (state_q == OUT);
    assign o_Busy    = (state_q != IDLE);
    assign o_Psum    = acc_q;
    assign o_Ovf     = ovf_q;
    assign accept    = o_Ready & i_Valid;
    assign last_beat = (cnt_q == len_q - LEN_W'(1));
    assign start_ok  = (state_q == IDLE) & i_Start;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_Start) state_d = ACCUM;
            ACCUM:   if (accept && last_beat) state_d = DRAIN;
            // The merge stage finishes on this edge when the operand stage is already empty.
            DRAIN:   if (!op_vld_q) state_d = OUT;
            OUT:     if (i_Ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= IDLE;
            pa_q      <= '0;
            pw_q      <= '0;
            len_q     <= LEN_W'(1);
            cnt_q     <= '0;
            op_vld_q  <= 1'b0;
            mrg_vld_q <= 1'b0;
            act_q     <= '0;
            wgt_q     <= '0;
            mrg_q     <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
        end else if (i_Flush) begin
            state_q   <= IDLE;
            op_vld_q  <= 1'b0;
            mrg_vld_q <= 1'b0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_vld_q  <= accept;
            mrg_vld_q <= op_vld_q;
            if (accept) begin
                act_q <= i_Act;
                wgt_q <= i_Weight;
                cnt_q <= cnt_q + LEN_W'(1);
            end
            if (op_vld_q) begin
                mrg_q <= merge_d;
            end
            if (start_ok) begin
                pa_q  <= (i_Precision[3:2] == 2'b11) ? 2'b00 : i_Precision[3:2];
                pw_q  <= (i_Precision[1:0] == 2'b11) ? 2'b00 : i_Precision[1:0];
                len_q <= (i_AccLen == '0) ? LEN_W'(1) : i_AccLen;
                cnt_q <= '0;
                acc_q <= i_Bias;
                ovf_q <= 1'b0;
            end else if (mrg_vld_q) begin
                acc_q <= sum_d;
                if (add_ovf) ovf_q <= 1'b1;
            end
        end
    end

endmodule
